// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: groups the two master request/response channels and the
// shared memory port of bus_arbiter into one bundle.
//   slave  modport : arbiter view (takes requests, drives memory port)
//   master modport : environment view (masters + memory slave)
// Parameter word_width sets every address/data width.
interface bus_arbiter_if #(parameter int word_width = 32);
  logic                  m0_req, m0_we, m0_gnt, m0_ack, m0_err;
  logic [word_width-1:0] m0_addr, m0_wdata, m0_rdata;
  logic                  m1_req, m1_we, m1_gnt, m1_ack, m1_err;
  logic [word_width-1:0] m1_addr, m1_wdata, m1_rdata;
  logic                  mem_en, mem_we, mem_ready;
  logic [word_width-1:0] mem_addr, mem_wdata, mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata, mem_ready,
    output m0_gnt, m0_ack, m0_err, m0_rdata,
    output m1_gnt, m1_ack, m1_err, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata, mem_ready,
    input  m0_gnt, m0_ack, m0_err, m0_rdata,
    input  m1_gnt, m1_ack, m1_err, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (m0 = cpu, m1 = vga) round-robin arbiter in front
// of a single memory port. One transaction at a time: IDLE -> ACCESS -> DONE.
// All outputs are registered.
// Ports:
//   clk        single clock, posedge
//   rst        synchronous active-high reset
//   bus        bus_arbiter_if.slave: master req/we/addr/wdata in,
//              gnt/ack/err/rdata out; memory en/we/addr/wdata out,
//              rdata/ready in
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to abort an ACCESS that
// sees no mem_ready within timeout_cycles cycles (ack + err to the owner).
module bus_arbiter #(
  parameter int word_width     = 32,
  parameter int timeout_cycles = 16
) (
  input logic       clk,
  input logic       rst,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  if (timeout_cycles < 1) begin : g_bad_tmo
    $error("bus_arbiter: timeout_cycles must be >= 1");
  end

  state_t                     state_q, state_d;
  logic                       owner_q, owner_d;   // 0 = m0, 1 = m1
  logic                       last_q, last_d;     // master served last
  logic [1:0]                 gnt_q, gnt_d, ack_q, ack_d;
  logic                       mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [word_width-1:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0][word_width-1:0] rdata_q, rdata_d;
  logic                       sel;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(timeout_cycles + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    err_q, err_d;
  logic          tmo;
  // High in the last allowed ACCESS cycle (cnt counts completed cycles).
  assign tmo = (cnt_q == CW'(timeout_cycles - 1));
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    sel         = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d    = '0;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (bus.m0_req || bus.m1_req) begin
          // Contention goes to whoever was not served last.
          sel         = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
          owner_d     = sel;
          state_d     = ACCESS;
          gnt_d       = sel ? 2'b10 : 2'b01;
          mem_en_d    = 1'b1;
          mem_we_d    = sel ? bus.m1_we    : bus.m0_we;
          mem_addr_d  = sel ? bus.m1_addr  : bus.m0_addr;
          mem_wdata_d = sel ? bus.m1_wdata : bus.m0_wdata;
`ifdef BUS_ARBITER_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ACCESS: begin
        // mem_ready takes priority over a simultaneous timeout.
        if (bus.mem_ready) begin
          if (!mem_we_q) rdata_d[owner_q] = bus.mem_rdata;
          ack_d[owner_q] = 1'b1;
          mem_en_d       = 1'b0;
          mem_we_d       = 1'b0;
          state_d        = DONE;
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (tmo) begin
          ack_d[owner_q] = 1'b1;
          err_d[owner_q] = 1'b1;
          mem_en_d       = 1'b0;
          mem_we_d       = 1'b0;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        gnt_d   = '0;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;   // pretend m1 went last so m0 wins first
      gnt_q       <= '0;
      ack_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.m0_gnt    = gnt_q[0];
  assign bus.m1_gnt    = gnt_q[1];
  assign bus.m0_ack    = ack_q[0];
  assign bus.m1_ack    = ack_q[1];
  assign bus.m0_rdata  = rdata_q[0];
  assign bus.m1_rdata  = rdata_q[1];
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
  assign bus.m0_err    = err_q[0];
  assign bus.m1_err    = err_q[1];
`else
  assign bus.m0_err    = 1'b0;
  assign bus.m1_err    = 1'b0;
`endif
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter word_width, default 32, width of every address and data port.
REQ-002 Parameter timeout_cycles, default 16, maximum ACCESS cycles when BUS_ARBITER_TIMEOUT_EN is defined.
REQ-003 clk  input  1  the single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_req / m1_req  input  1  access request from master 0 (cpu) / master 1 (vga); held until ack.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read; held with req.
REQ-007 m0_addr / m1_addr  input  word_width  access address; held with req.
REQ-008 m0_wdata / m1_wdata  input  word_width  write data; held with req.
REQ-009 m0_gnt / m1_gnt  output  1  master owns the bus for the current transaction.
REQ-010 m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-011 m0_err / m1_err  output  1  one-cycle pulse with ack on an aborted transaction.
REQ-012 m0_rdata / m1_rdata  output  word_width  read data; valid in the ack cycle, held until next ack to the same master.
REQ-013 mem_en  output  1  shared memory port access strobe.
REQ-014 mem_we  output  1  shared port write enable.
REQ-015 mem_addr  output  word_width  shared port address.
REQ-016 mem_wdata  output  word_width  shared port write data.
REQ-017 mem_rdata  input  word_width  shared port read data, valid with mem_ready.
REQ-018 mem_ready  input  1  slave completion, any cycle while mem_en is high.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE; all outputs registered.
REQ-020 IDLE: no req -> stay IDLE. One req -> latch owner, we, addr, wdata -> ACCESS.
REQ-021 IDLE with both req: grant the master not served last (round-robin pointer); pointer after reset favours m0.
REQ-022 ACCESS: mem_en=1, gnt of owner=1, mem_we/addr/wdata = latched values, constant for the whole state.
REQ-023 Latency: req sampled high at edge N -> mem_en and gnt high from cycle N+1.
REQ-024 ACCESS with mem_ready=1 at edge M -> capture mem_rdata into owner rdata on reads (rdata unchanged on writes), -> DONE; mem_en low from cycle M+1.
REQ-025 DONE lasts exactly one cycle: owner ack=1, gnt=1, then -> IDLE; pointer updated to owner.
REQ-026 Masters deassert req at the edge after sampling ack; a req still high in the following IDLE is a new transaction.
REQ-027 The non-owner's req is ignored during ACCESS/DONE; non-owner gnt, ack, err remain 0.
REQ-028 At most one gnt high in any cycle; ack/err never high outside DONE.
REQ-029 Back-to-back minimum: one idle cycle between transactions (DONE -> IDLE -> ACCESS).
REQ-030 mem_ready outside ACCESS is ignored.

Reset
REQ-031 rst high at a clock edge -> state IDLE, pointer favours m0, all gnt/ack/err/mem_en/mem_we = 0, mem_addr/mem_wdata/rdata = 0.
REQ-032 rst mid-ACCESS aborts the transaction with no ack and no err; rst dominates all other inputs.

Configuration
REQ-033 Macro BUS_ARBITER_TIMEOUT_EN: when defined, a counter counts ACCESS cycles; if timeout_cycles ACCESS cycles elapse without mem_ready -> DONE with ack=1 and err=1 to the owner, rdata unchanged, mem_en dropped.
REQ-034 Without BUS_ARBITER_TIMEOUT_EN: no counter, ACCESS waits for mem_ready indefinitely, m0_err/m1_err tied 0.
REQ-035 Timeout and mem_ready in the same cycle -> mem_ready wins, err=0.

Verification
REQ-036 After reset, m0 read addr 0x10, mem_ready one cycle after mem_en with rdata 0xDEADBEEF -> m0_ack one cycle, m0_rdata=0xDEADBEEF, m1 outputs 0.
REQ-037 Both req at the same edge after reset -> m0 served first, then m1 on the next IDLE; repeat -> alternation m0,m1,m0,m1.
REQ-038 m1 write addr 0x20 data 0x5, mem_ready delayed 5 cycles -> mem_en/mem_addr/mem_wdata stable for 5 cycles, m1_ack once, m1_rdata unchanged.
REQ-039 rst asserted in the 2nd ACCESS cycle -> next cycle all outputs 0, state IDLE, no ack.
REQ-040 TIMEOUT_EN, timeout_cycles=4, mem_ready never high -> ack and err pulse after 4 ACCESS cycles; without macro -> mem_en held, no ack.
